// File: rtl/mipi_csi_rx_line_scheduler_if.sv
// Header/payload bus from the CSI packet decoder and the depacker-facing
// bus from the line scheduler, bundled as one interface.
interface mipi_csi_rx_line_scheduler_if;
  logic        hdr_valid_i;
  logic [7:0]  hdr_data_id_i;
  logic [15:0] hdr_word_count_i;
  logic        payload_valid_i;
  logic [15:0] payload_i;
  logic        depack_valid_o;
  logic [15:0] depack_data_o;
  logic [2:0]  depack_type_o;

  // Packet decoder side: drives headers/payload, observes the depacker bus.
  modport master (
    output hdr_valid_i, hdr_data_id_i, hdr_word_count_i, payload_valid_i, payload_i,
    input  depack_valid_o, depack_data_o, depack_type_o
  );

  // Line scheduler side.
  modport slave (
    input  hdr_valid_i, hdr_data_id_i, hdr_word_count_i, payload_valid_i, payload_i,
    output depack_valid_o, depack_data_o, depack_type_o
  );
endinterface

// File: rtl/mipi_csi_rx_line_scheduler.sv
// CSI-2 receive line scheduler: tracks frame/line state from packet headers,
// gates payload beats into the 2-lane raw depacker after an idle gap, and
// flags unsupported packet types and payload length errors.
module mipi_csi_rx_line_scheduler #(
  parameter int GAP_CYCLES = 2,
  parameter int LINE_CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  mipi_csi_rx_line_scheduler_if.slave bus,
  output logic                  frame_valid_o,
  output logic [LINE_CNT_W-1:0] line_count_o,
  output logic                  busy_o,
  output logic                  err_type_o,
  output logic                  err_len_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_IN_FRAME = 3'd1;
  localparam logic [2:0] S_GAP      = 3'd2;
  localparam logic [2:0] S_LINE     = 3'd3;
  localparam logic [2:0] S_DROP     = 3'd4;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

  logic [2:0]            r_state;
  logic [3:0]            r_gap_cnt;
  logic [15:0]           r_beats_left;
  logic                  r_depack_valid;
  logic [15:0]           r_depack_data;
  logic [2:0]            r_depack_type;
  logic                  r_frame_valid;
  logic [LINE_CNT_W-1:0] r_line_count;
  logic                  r_err_type;
  logic                  r_err_len;

  logic [5:0]  w_dt;
  logic        w_short;
  logic        w_fs;
  logic        w_fe;
  logic        w_long;
  logic        w_supported;
  logic [16:0] w_wc_p1;
  logic [15:0] w_beats;
  logic        w_last;

  // Header decode; bits [7:6] carry the virtual channel, which this block ignores.
  assign w_dt        = bus.hdr_data_id_i[5:0];
  assign w_short     = bus.hdr_valid_i && (w_dt < 6'h10);
  assign w_fs        = w_short && (w_dt == 6'h00);
  assign w_fe        = w_short && (w_dt == 6'h01);
  assign w_long      = bus.hdr_valid_i && (w_dt >= 6'h10);
  assign w_supported = (w_dt == 6'h2B) || (w_dt == 6'h2C) || (w_dt == 6'h2D);
  // Two bytes per beat: beats = ceil(wc / 2), computed one bit wider so 0xFFFF does not wrap.
  assign w_wc_p1     = {1'b0, bus.hdr_word_count_i} + 17'd1;
  assign w_beats     = w_wc_p1[16:1];
  assign w_last      = bus.payload_valid_i && (r_beats_left == 16'd1);

  // Frame/line state machine with the forwarding register and error pulses.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state        <= S_IDLE;
      r_gap_cnt      <= '0;
      r_beats_left   <= '0;
      r_depack_valid <= 1'b0;
      r_depack_data  <= '0;
      r_depack_type  <= 3'b011;
      r_frame_valid  <= 1'b0;
      r_line_count   <= '0;
      r_err_type     <= 1'b0;
      r_err_len      <= 1'b0;
    end else begin
      r_err_type     <= 1'b0;
      r_err_len      <= 1'b0;
      r_depack_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fs) begin
            r_frame_valid <= 1'b1;
            r_line_count  <= '0;
            r_state       <= S_IN_FRAME;
          end else if (w_long) begin
            r_state <= S_DROP;
          end
        end
        S_IN_FRAME: begin
          if (w_fs) begin
            r_line_count <= '0;
          end else if (w_fe) begin
            r_frame_valid <= 1'b0;
            r_state       <= S_IDLE;
          end else if (w_long) begin
            if (!w_supported) begin
              r_err_type <= 1'b1;
              r_state    <= S_DROP;
            end else if (bus.hdr_word_count_i == 16'd0) begin
              r_err_len <= 1'b1;
              r_state   <= S_DROP;
            end else begin
              r_depack_type <= w_dt[2:0];
              r_beats_left  <= w_beats;
              r_gap_cnt     <= GAP_LOAD;
              r_state       <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (w_fs) begin
            r_err_len     <= 1'b1;
            r_line_count  <= '0;
            r_frame_valid <= 1'b1;
            r_state       <= S_IN_FRAME;
          end else if (w_fe) begin
            r_err_len     <= 1'b1;
            r_frame_valid <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            // Early beats and stray headers are discarded; the gap still runs down.
            if (bus.hdr_valid_i || bus.payload_valid_i) r_err_len <= 1'b1;
            if (r_gap_cnt > 4'd1)           r_gap_cnt <= r_gap_cnt - 4'd1;
            else if (!bus.payload_valid_i) begin
              r_gap_cnt <= '0;
              r_state   <= S_LINE;
            end
          end
        end
        S_LINE: begin
          if (w_fs) begin
            r_err_len     <= 1'b1;
            r_line_count  <= '0;
            r_frame_valid <= 1'b1;
            r_state       <= S_IN_FRAME;
          end else if (w_fe && !w_last) begin
            r_err_len     <= 1'b1;
            r_frame_valid <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            if (bus.hdr_valid_i && !w_fe) r_err_len <= 1'b1;
            if (bus.payload_valid_i) begin
              r_depack_valid <= 1'b1;
              r_depack_data  <= bus.payload_i;
              r_beats_left   <= r_beats_left - 16'd1;
              if (w_last) begin
                // Line counted before a coincident FE closes the frame.
                r_line_count <= r_line_count + 1'b1;
                r_state      <= S_DROP;
                if (w_fe) r_frame_valid <= 1'b0;
              end
            end else begin
              r_err_len <= 1'b1;
              r_state   <= S_IN_FRAME;
            end
          end
        end
        S_DROP: begin
          if (w_fs) begin
            r_err_len     <= 1'b1;
            r_line_count  <= '0;
            r_frame_valid <= 1'b1;
            r_state       <= S_IN_FRAME;
          end else if (!bus.payload_valid_i) begin
            if (w_fe) r_frame_valid <= 1'b0;
            r_state <= (r_frame_valid && !w_fe) ? S_IN_FRAME : S_IDLE;
          end else if (w_fe) begin
            r_frame_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.depack_valid_o = r_depack_valid;
  assign bus.depack_data_o  = r_depack_data;
  assign bus.depack_type_o  = r_depack_type;
  assign frame_valid_o      = r_frame_valid;
  assign line_count_o       = r_line_count;
  assign busy_o             = (r_state != S_IDLE) && (r_state != S_IN_FRAME);
  assign err_type_o         = r_err_type;
  assign err_len_o          = r_err_len;

endmodule

// File: tb/tb_mipi_csi_rx_line_scheduler.sv
// Directed bench for the CSI-2 receive line scheduler.
module tb_mipi_csi_rx_line_scheduler;
  logic        clk;
  logic        reset_n;
  logic        frame_valid;
  logic [15:0] line_count;
  logic        busy;
  logic        err_type;
  logic        err_len;
  int          n_run;
  int          n_fail;

  mipi_csi_rx_line_scheduler_if bus ();

  mipi_csi_rx_line_scheduler #(.GAP_CYCLES(2), .LINE_CNT_W(16)) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .bus           (bus),
    .frame_valid_o (frame_valid),
    .line_count_o  (line_count),
    .busy_o        (busy),
    .err_type_o    (err_type),
    .err_len_o     (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_fs();
    bus.hdr_valid_i = 1'b1; bus.hdr_data_id_i = 8'h00; bus.hdr_word_count_i = 16'h0;
    tick();
    bus.hdr_valid_i = 1'b0;
    chk("fs_frame_valid", 32'(frame_valid), 1);
    chk("fs_line_count", 32'(line_count), 0);
  endtask

  // Header, two gap cycles, nb beats, then payload_valid low for one cycle.
  task automatic run_line(input logic [7:0] dt, input int wc, input int nb,
                          input logic exp_err, input logic [2:0] exp_type,
                          input logic [15:0] base);
    int need;
    need = (wc + 1) / 2;
    bus.hdr_valid_i = 1'b1; bus.hdr_data_id_i = dt; bus.hdr_word_count_i = 16'(wc);
    tick();
    bus.hdr_valid_i = 1'b0;
    chk("hdr_type", 32'(bus.depack_type_o), 32'(exp_type));
    chk("hdr_valid_low", 32'(bus.depack_valid_o), 0);
    chk("hdr_busy", 32'(busy), 1);
    tick();
    chk("gap1_valid_low", 32'(bus.depack_valid_o), 0);
    chk("gap1_type", 32'(bus.depack_type_o), 32'(exp_type));
    tick();
    chk("gap2_valid_low", 32'(bus.depack_valid_o), 0);
    for (int k = 0; k < nb; k++) begin
      bus.payload_valid_i = 1'b1;
      bus.payload_i = 16'(base + 16'(k));
      tick();
      chk("beat_valid", 32'(bus.depack_valid_o), (k < need) ? 1 : 0);
      if (k < need) chk("beat_data", 32'(bus.depack_data_o), 32'(16'(base + 16'(k))));
      chk("beat_type", 32'(bus.depack_type_o), 32'(exp_type));
      chk("beat_err_len", 32'(err_len), 0);
    end
    bus.payload_valid_i = 1'b0;
    tick();
    chk("end_valid_low", 32'(bus.depack_valid_o), 0);
    chk("end_err_len", 32'(err_len), 32'(exp_err));
    chk("end_busy", 32'(busy), 0);
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    reset_n = 1'b0;
    bus.hdr_valid_i = 1'b0; bus.hdr_data_id_i = 8'h0; bus.hdr_word_count_i = 16'h0;
    bus.payload_valid_i = 1'b0; bus.payload_i = 16'h0;
    repeat (3) tick();
    chk("rst_valid", 32'(bus.depack_valid_o), 0);
    chk("rst_data", 32'(bus.depack_data_o), 0);
    chk("rst_type", 32'(bus.depack_type_o), 3);
    chk("rst_frame", 32'(frame_valid), 0);
    chk("rst_lines", 32'(line_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err_type", 32'(err_type), 0);
    chk("rst_err_len", 32'(err_len), 0);
    reset_n = 1'b1;
    tick();

    // Single RAW10 line, 5 beats.
    send_fs();
    run_line(8'h2B, 10, 5, 1'b0, 3'b011, 16'h1100);
    chk("t1_lines", 32'(line_count), 1);

    // Three RAW12 lines then FE.
    send_fs();
    run_line(8'h2C, 6, 3, 1'b0, 3'b100, 16'h2100);
    run_line(8'h2C, 6, 3, 1'b0, 3'b100, 16'h2200);
    run_line(8'h2C, 6, 3, 1'b0, 3'b100, 16'h2300);
    chk("t2_lines", 32'(line_count), 3);
    bus.hdr_valid_i = 1'b1; bus.hdr_data_id_i = 8'h01;
    tick();
    bus.hdr_valid_i = 1'b0;
    chk("t2_fe_frame", 32'(frame_valid), 0);
    chk("t2_fe_lines", 32'(line_count), 3);
    chk("t2_fe_busy", 32'(busy), 0);

    // Short line: 3 of 5 beats.
    send_fs();
    run_line(8'h2B, 10, 3, 1'b1, 3'b011, 16'h3100);
    chk("t3_lines", 32'(line_count), 0);
    tick();
    chk("t3_err_single", 32'(err_len), 0);

    // Unsupported YUV422 type is dropped.
    bus.hdr_valid_i = 1'b1; bus.hdr_data_id_i = 8'h1E; bus.hdr_word_count_i = 16'd8;
    tick();
    bus.hdr_valid_i = 1'b0;
    chk("t4_err_type", 32'(err_type), 1);
    chk("t4_err_len", 32'(err_len), 0);
    chk("t4_busy", 32'(busy), 1);
    for (int k = 0; k < 4; k++) begin
      bus.payload_valid_i = 1'b1; bus.payload_i = 16'(16'h4100 + 16'(k));
      tick();
      chk("t4_drop_valid", 32'(bus.depack_valid_o), 0);
      chk("t4_err_type_clear", 32'(err_type), 0);
    end
    bus.payload_valid_i = 1'b0;
    tick();
    chk("t4_busy_end", 32'(busy), 0);
    chk("t4_frame", 32'(frame_valid), 1);

    // Overlong RAW14 line, then FS in the middle of the next line.
    run_line(8'h2D, 4, 6, 1'b0, 3'b101, 16'h5500);
    chk("t5_lines", 32'(line_count), 1);
    bus.hdr_valid_i = 1'b1; bus.hdr_data_id_i = 8'h2B; bus.hdr_word_count_i = 16'd10;
    tick();
    bus.hdr_valid_i = 1'b0;
    tick();
    tick();
    bus.payload_valid_i = 1'b1; bus.payload_i = 16'h6600;
    tick();
    chk("t5_beat_valid", 32'(bus.depack_valid_o), 1);
    chk("t5_beat_type", 32'(bus.depack_type_o), 3);
    bus.payload_valid_i = 1'b0;
    bus.hdr_valid_i = 1'b1; bus.hdr_data_id_i = 8'h00;
    tick();
    bus.hdr_valid_i = 1'b0;
    chk("t5_fs_err_len", 32'(err_len), 1);
    chk("t5_fs_lines", 32'(line_count), 0);
    chk("t5_fs_valid", 32'(bus.depack_valid_o), 0);
    chk("t5_fs_busy", 32'(busy), 0);
    chk("t5_fs_frame", 32'(frame_valid), 1);
    tick();
    chk("t5_err_clear", 32'(err_len), 0);

    // Reset mid-line.
    bus.hdr_valid_i = 1'b1; bus.hdr_data_id_i = 8'h2C; bus.hdr_word_count_i = 16'd8;
    tick();
    bus.hdr_valid_i = 1'b0;
    tick();
    tick();
    bus.payload_valid_i = 1'b1; bus.payload_i = 16'h7100;
    tick();
    bus.payload_i = 16'h7101;
    tick();
    chk("t6_pre_valid", 32'(bus.depack_valid_o), 1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.depack_valid_o), 0);
    chk("t6_rst_data", 32'(bus.depack_data_o), 0);
    chk("t6_rst_type", 32'(bus.depack_type_o), 3);
    chk("t6_rst_frame", 32'(frame_valid), 0);
    chk("t6_rst_lines", 32'(line_count), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_err_len", 32'(err_len), 0);
    chk("t6_rst_err_type", 32'(err_type), 0);
    bus.payload_valid_i = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Recovery with an odd word count line.
    send_fs();
    run_line(8'h2B, 5, 3, 1'b0, 3'b011, 16'h8100);
    chk("t7_lines", 32'(line_count), 1);

    // FE on the cycle of the last beat: line counted, then frame closes.
    bus.hdr_valid_i = 1'b1; bus.hdr_data_id_i = 8'h2B; bus.hdr_word_count_i = 16'd2;
    tick();
    bus.hdr_valid_i = 1'b0;
    tick();
    tick();
    bus.payload_valid_i = 1'b1; bus.payload_i = 16'h9900;
    bus.hdr_valid_i = 1'b1; bus.hdr_data_id_i = 8'h01;
    tick();
    bus.hdr_valid_i = 1'b0;
    bus.payload_valid_i = 1'b0;
    chk("t8_valid", 32'(bus.depack_valid_o), 1);
    chk("t8_data", 32'(bus.depack_data_o), 32'h9900);
    chk("t8_lines", 32'(line_count), 2);
    chk("t8_frame", 32'(frame_valid), 0);
    chk("t8_err_len", 32'(err_len), 0);
    tick();
    chk("t8_busy", 32'(busy), 0);
    chk("t8_valid_low", 32'(bus.depack_valid_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/mipi_csi_rx_line_scheduler.md
Name: mipi_csi_rx_line_scheduler

Overview:
- Sits between the CSI packet decoder and the 2-lane raw depacker.
- Parses packet headers and tracks frame and line state.
- Gates payload bytes into the depacker and presents a stable packet type before each line.
- Enforces the mandatory idle gap between lines, counts payload bytes against word count, and flags unsupported types and length errors.

Parameters:
- GAP_CYCLES, 2, cycles depack_valid_o is held low before each line; legal range 1..15.
- LINE_CNT_W, 16, width of line_count_o.

Ports:
- clk_i  input  1  system byte clock
- reset_n_i  input  1  asynchronous active-low reset
- hdr_valid_i  input  1  one-cycle strobe: header fields valid
- hdr_data_id_i  input  8  CSI data identifier; bits [5:0] are the data type
- hdr_word_count_i  input  16  long packet: payload byte count; short packet: ignored
- payload_valid_i  input  1  payload beat valid; stays high for the whole packet
- payload_i  input  16  two lane bytes per beat, lane 1 in [7:0]
- depack_valid_o  output  1  drives depacker data_valid_i
- depack_data_o  output  16  drives depacker data_i
- depack_type_o  output  3  data type [2:0]; drives depacker packet_type_i
- frame_valid_o  output  1  high between frame start (FS) and frame end (FE)
- line_count_o  output  LINE_CNT_W  completed lines in the current frame
- busy_o  output  1  state != IDLE/IN_FRAME
- err_type_o  output  1  one-cycle pulse: unsupported long-packet type
- err_len_o  output  1  one-cycle pulse: payload length mismatch or aborted line

Behaviour:
- Reset (asynchronous, active low): all outputs 0; depack_type_o = 3'b011 (RAW10); state IDLE; all counters 0.
- States:
  - IDLE: no frame open.
  - IN_FRAME: frame open, between lines.
  - GAP: inter-line gap countdown.
  - LINE: forwarding payload.
  - DROP: discarding a packet.
- Short packets are decoded when hdr_valid_i=1 and data type < 0x10:
  - 0x00 FS: frame_valid_o<=1, line_count_o<=0, IDLE->IN_FRAME. An FS received in IN_FRAME restarts the frame. An FS received in GAP/LINE/DROP aborts the line: err_len_o pulse, state IN_FRAME.
  - 0x01 FE: frame_valid_o<=0, state IDLE. An FE received in GAP/LINE also aborts the line with an err_len_o pulse.
  - 0x02/0x03 line start/end: ignored.
- Long packet accepted in IN_FRAME with data type 0x2B/0x2C/0x2D:
  - depack_type_o <= type[2:0] on the next edge.
  - beats_left <= ceil(wc/2).
  - GAP counter loaded with GAP_CYCLES; state GAP.
  - depack_type_o changes only while depack_valid_o=0 and is stable for at least GAP_CYCLES cycles before depack_valid_o rises.
- Long packet with any other data type in IN_FRAME: err_type_o pulse, state DROP.
- Long packet received while in IDLE: state DROP, no error.
- Zero word count: err_len_o pulse, state DROP.
- GAP: counter decrements each cycle; at 0, state LINE. A payload beat that arrives while in GAP is discarded with an err_len_o pulse, and the state stays GAP.
- LINE, each cycle with payload_valid_i=1:
  - depack_data_o<=payload_i and depack_valid_o<=1, giving one-cycle latency.
  - beats_left decrements.
  - On the last beat: line_count_o increments (wrapping at 2^LINE_CNT_W), then state DROP to discard trailing beats. depack_valid_o falls the cycle after the last beat.
- LINE, payload_valid_i=0 while beats_left>0: depack_valid_o<=0, err_len_o pulse, line_count_o unchanged, state IN_FRAME.
- DROP: wait until payload_valid_i=0, then go to IN_FRAME if frame_valid_o=1, else IDLE. Trailing beats are never forwarded.
- A header arriving while in GAP/LINE (other than FS/FE) is ignored with an err_len_o pulse.
- Odd word count: the final beat is forwarded whole; the depacker discards the padding byte.
- Simultaneous FE and line completion in the same cycle: the line is counted first, then the frame closes.
- Reset asserted mid-line: depack_valid_o drops asynchronously, with no error pulses.

Test Plan:
- FS, then RAW10 header wc=10, then 5 beats -> depack_type_o=3'b011 stable ≥2 cycles before depack_valid_o rises; 5 valid cycles with data delayed 1 clock; line_count_o=1.
- FS, then 3 lines of RAW12 wc=6, then FE -> each depack_valid_o rise preceded by ≥2 low cycles; line_count_o=3; frame_valid_o falls after FE.
- RAW10 wc=10 with only 3 beats -> err_len_o single pulse; depack_valid_o low after 3 cycles; line_count_o=0.
- Header with data type 0x1E (YUV422) -> err_type_o pulse; payload never forwarded; returns to IN_FRAME.
- wc=4 with 6 beats -> 2 beats forwarded, 4 dropped, no error; then FS mid-next-line -> err_len_o pulse, line_count_o=0.
- Reset asserted during LINE -> all outputs 0 immediately; next FS/line is processed normally.
